// File: rtl/arb_ram_pkg.sv
// Shared types and default parameter constants for the arbitrated single-port RAM.
package arb_ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int NCH_DEF    = 2;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 1024;
  localparam int ADDR_W_DEF = 32;

endpackage

// File: rtl/arb_ram_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest-indexed requester at or
// above ptr, wrapping modulo NCH. Output is one-hot or zero.
module rr_arbiter #(
  parameter int NCH   = 2,
  parameter int PTR_W = 1
) (
  input  logic [NCH-1:0]   req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NCH-1:0]   gnt
);

  logic [2*NCH-1:0] req_dbl;
  logic [2*NCH-1:0] gnt_dbl;
  logic [NCH-1:0]   rot;
  logic [NCH-1:0]   sel;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    rot     = req_dbl[NCH-1:0];
    sel     = rot & (-rot);
    gnt_dbl = {{NCH{1'b0}}, sel} << ptr;
    gnt     = gnt_dbl[NCH-1:0] | gnt_dbl[2*NCH-1:NCH];
  end

endmodule

// File: rtl/arb_ram.sv
// Multi-channel round-robin arbitrated single-port RAM with a zeroing sweep after reset.
// Optional macro ARB_RAM_OUTREG_EN adds an output register stage (read latency 2).
module arb_ram
  import arb_ram_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic [NCH-1:0]             req_i,
  input  logic [NCH*ADDR_W-1:0]      addr_i,
  input  logic [NCH*(DATA_W/8)-1:0]  we_i,
  input  logic [NCH*DATA_W-1:0]      wdata_i,
  output logic [NCH-1:0]             gnt_o,
  output logic [NCH-1:0]             rvalid_o,
  output logic [NCH*DATA_W-1:0]      rdata_o,
  output logic                       init_done_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_e             state;
  logic [IDX_W-1:0]   cnt;
  logic [PTR_W-1:0]   ptr;
  logic               init_done;
  logic [NCH-1:0]     arb_gnt;
  logic [NCH-1:0]     gnt;

  logic [ADDR_W-1:0]  sel_addr;
  logic [NB-1:0]      sel_we;
  logic [DATA_W-1:0]  sel_wdata;
  logic [PTR_W-1:0]   sel_ch;
  logic               any_gnt;
  logic               rd;
  logic               wr;
  logic [IDX_W-1:0]   mem_idx;
  logic               unused_addr;

  logic [DATA_W-1:0]  mem [DEPTH];

  rr_arbiter #(
    .NCH   (NCH),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req_i),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  assign gnt         = (state == RUN) ? arb_gnt : '0;
  assign gnt_o       = gnt;
  assign init_done_o = init_done;

  always_comb begin
    sel_addr  = '0;
    sel_we    = '0;
    sel_wdata = '0;
    sel_ch    = '0;
    any_gnt   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (gnt[c]) begin
        sel_addr  = addr_i[c*ADDR_W +: ADDR_W];
        sel_we    = we_i[c*NB +: NB];
        sel_wdata = wdata_i[c*DATA_W +: DATA_W];
        sel_ch    = PTR_W'(c);
        any_gnt   = 1'b1;
      end
    end
  end

  // Upper address bits wrap and byte-offset bits are don't-care.
  assign unused_addr = ^sel_addr;
  assign rd          = any_gnt && (sel_we == '0);
  assign wr          = any_gnt && (sel_we != '0);
  assign mem_idx     = (state == INIT) ? cnt : sel_addr[IDX_W+OFF_W-1:OFF_W];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state     <= INIT;
      cnt       <= '0;
      ptr       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + IDX_W'(1);
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (any_gnt) begin
            ptr <= (sel_ch == PTR_W'(NCH - 1)) ? '0 : sel_ch + PTR_W'(1);
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Single shared port: the sweep and granted writes both go through mem_idx.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[mem_idx] <= '0;
    end else if (wr) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_we[b]) mem[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  // Stage p1: read data captured into the granted channel's holding register.
  logic [NCH-1:0]    vld_p1;
  logic [DATA_W-1:0] rdata_p1 [NCH];
  logic [NCH-1:0]    vld_out;
  logic [DATA_W-1:0] rdata_out [NCH];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      vld_p1 <= '0;
      for (int c = 0; c < NCH; c++) rdata_p1[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        vld_p1[c] <= rd && gnt[c];
        if (rd && gnt[c]) rdata_p1[c] <= mem[mem_idx];
      end
    end
  end

`ifdef ARB_RAM_OUTREG_EN
  // Stage p2: extra output register, valid delayed alongside.
  logic [NCH-1:0]    vld_p2;
  logic [DATA_W-1:0] rdata_p2 [NCH];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      vld_p2 <= '0;
      for (int c = 0; c < NCH; c++) rdata_p2[c] <= '0;
    end else begin
      vld_p2 <= vld_p1;
      for (int c = 0; c < NCH; c++) rdata_p2[c] <= rdata_p1[c];
    end
  end

  assign vld_out   = vld_p2;
  assign rdata_out = rdata_p2;
`else
  assign vld_out   = vld_p1;
  assign rdata_out = rdata_p1;
`endif

  assign rvalid_o = vld_out;

  always_comb begin
    rdata_o = '0;
    for (int c = 0; c < NCH; c++) rdata_o[c*DATA_W +: DATA_W] = rdata_out[c];
  end

endmodule
